lfsr_seq_gen: RTL and testbench
===============================

// Module: lfsr_seq_gen
// PURPOSE
//  Parametrised pseudo-random symbol generator for game sequences (Simon colour/tone select).
//  Fibonacci LFSR with configurable width, tap mask and output slice.
//  Adds a checkpoint/replay mechanism and a sequence-position counter, so the controller can
//  replay round N identically and detect the end of the current round.
// PARAMETERS
//  WIDTH     16         LFSR width, bits (>=4)
//  TAPS      16'h002D   feedback mask; fb = ^(lfsr & TAPS); default taps bits 0,2,3,5
//  FILL      16'hACE1   reset/fallback state; must be nonzero
//  OUT_BITS  4          width of random output (<=WIDTH)
//  MAX_LEN   32         max sequence length; IDXW = $clog2(MAX_LEN)
// PORTS
//  clk        in   1         rising-edge clock
//  reset      in   1         synchronous, active-high
//  step       in   1         advance one symbol (single-cycle pulse)
//  randomize  in   1         level; LFSR free-runs while high; falling edge sets checkpoint
//  rerun      in   1         restore LFSR to checkpoint, clear index
//  round_len  in   IDXW      index value at which the round ends
//  random     out  OUT_BITS  current symbol = lfsr[OUT_BITS-1:0]
//  index      out  IDXW      symbols stepped since last checkpoint/rerun
//  last       out  1         combinational: index == round_len
//  seed_load  in   1         (LFSR_SEQ_SEED_EN only) load seed_in
//  seed_in    in   WIDTH     (LFSR_SEQ_SEED_EN only) seed value
// BEHAVIOUR
//  - Reset: lfsr=FILL, checkpoint=FILL, index=0, randomize_d=0; random=FILL[OUT_BITS-1:0].
//  - Shift: lfsr <= {fb, lfsr[WIDTH-1:1]}; random/index change 1 cycle after qualifying input.
//  - Priority per cycle: reset > rerun > seed_load > randomize > step.
//  - rerun: lfsr<=checkpoint, index<=0; randomize/step/capture ignored that cycle.
//  - randomize high: shift every cycle; index<=0; step ignored.
//  - Falling edge (randomize==0 && randomize_d==1): checkpoint<=lfsr (value in that cycle,
//    i.e. after last free-run shift), index<=0. Suppressed if rerun same cycle.
//  - step with last==0: shift once, index<=index+1. Step with last==1: ignored (no shift,
//    index holds). round_len >= MAX_LEN: index saturates at MAX_LEN-1, no wrap.
//  - randomize_d tracks randomize every non-reset cycle, incl. rerun cycles.
//  - Lock-up: lfsr never zero; any write of all-zeros substitutes FILL.
//  - Reset mid-round/mid-randomize: full return to reset state, no edge detected afterwards.
// CONFIGURATION
//  LFSR_SEQ_SEED_EN defined: seed_load/seed_in ports exist; seed_load: lfsr<=seed_in
//    (0 -> FILL), checkpoint<=same value, index<=0.
//  Undefined: ports absent; seeding only via randomize timing.
// TESTING
//  1 reset -> random=4'h1, index=0, last=(round_len==0).
//  2 reset, round_len=5, step x2 -> lfsr 16'h5670 then 16'hAB38; random 0 then 8; index=2.
//  3 reset, randomize high 3 clk then low -> checkpoint=16'h559C, index=0;
//    step x3, rerun -> lfsr=16'h559C, index=0, random=4'hC.
//  4 round_len=2: step x4 -> index stops at 2, last=1, lfsr stops after 2nd step.
//  5 rerun and randomize falling edge same cycle -> lfsr=old checkpoint, checkpoint unchanged.
//  6 (LFSR_SEQ_SEED_EN) seed_load seed_in=0 -> lfsr=FILL; seed_in=16'h1234 -> random=4'h4.

Source files
------------

// File: rtl/lfsr_seq_gen_if.sv
// Control/status bundle between a game controller (master) and lfsr_seq_gen (slave).
// The seed_load/seed_in pair exists only when LFSR_SEQ_SEED_EN is defined.
interface lfsr_seq_gen_if #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned OUT_BITS = 4,
  parameter int unsigned MAX_LEN  = 32
);
  localparam int unsigned IDXW = $clog2(MAX_LEN);

  logic                step;
  logic                randomize_en;
  logic                rerun;
  logic [IDXW-1:0]     round_len;
  logic [OUT_BITS-1:0] random;
  logic [IDXW-1:0]     index;
  logic                last;
`ifdef LFSR_SEQ_SEED_EN
  logic                seed_load;
  logic [WIDTH-1:0]    seed_in;
`endif

  if (OUT_BITS > WIDTH) begin : g_bad_out_bits
    $error("OUT_BITS must not exceed WIDTH");
  end

  modport master (
    output step, randomize_en, rerun, round_len,
`ifdef LFSR_SEQ_SEED_EN
    output seed_load, seed_in,
`endif
    input  random, index, last
  );

  modport slave (
    input  step, randomize_en, rerun, round_len,
`ifdef LFSR_SEQ_SEED_EN
    input  seed_load, seed_in,
`endif
    output random, index, last
  );
endinterface

// File: rtl/lfsr_seq_gen.sv
// Fibonacci-LFSR symbol generator with checkpoint/replay and round-position counter.
// Define LFSR_SEQ_SEED_EN to add direct seeding through seed_load/seed_in.
module lfsr_seq_gen #(
  parameter int unsigned      WIDTH    = 16,
  parameter logic [WIDTH-1:0] TAPS     = 16'h002D,
  parameter logic [WIDTH-1:0] FILL     = 16'hACE1,
  parameter int unsigned      OUT_BITS = 4,
  parameter int unsigned      MAX_LEN  = 32
) (
  input logic           clk,
  input logic           reset,
  lfsr_seq_gen_if.slave bus
);
  localparam int unsigned     IDXW   = $clog2(MAX_LEN);
  localparam logic [IDXW-1:0] IdxMax = IDXW'(MAX_LEN - 1);

  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] chk_q, chk_d;
  logic [WIDTH-1:0] shifted;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             rand_q;
  logic             last;
  logic             fall;

  assign shifted = {^(lfsr_q & TAPS), lfsr_q[WIDTH-1:1]};
  assign last    = (idx_q == bus.round_len);
  assign fall    = ~bus.randomize_en & rand_q;

  always_comb begin
    lfsr_d = lfsr_q;
    chk_d  = chk_q;
    idx_d  = idx_q;
    if (bus.rerun) begin
      lfsr_d = chk_q;
      idx_d  = '0;
    end
`ifdef LFSR_SEQ_SEED_EN
    else if (bus.seed_load) begin
      lfsr_d = bus.seed_in;
      chk_d  = bus.seed_in;
      idx_d  = '0;
    end
`endif
    else if (bus.randomize_en) begin
      lfsr_d = shifted;
      idx_d  = '0;
    end else if (fall) begin
      // Checkpoint is the state left by the final free-run shift.
      chk_d = lfsr_q;
      idx_d = '0;
    end else if (bus.step && !last) begin
      lfsr_d = shifted;
      if (idx_q != IdxMax) idx_d = idx_q + IDXW'(1);
    end
    // All-zeros is the LFSR lock-up state; never let it in.
    if (lfsr_d == '0) lfsr_d = FILL;
    if (chk_d == '0)  chk_d  = FILL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= FILL;
      chk_q  <= FILL;
      idx_q  <= '0;
      rand_q <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      chk_q  <= chk_d;
      idx_q  <= idx_d;
      rand_q <= bus.randomize_en;
    end
  end

  assign bus.random = lfsr_q[OUT_BITS-1:0];
  assign bus.index  = idx_q;
  assign bus.last   = last;
endmodule

// File: tb/tb_lfsr_seq_gen.sv
// Self-checking bench for lfsr_seq_gen: directed scenarios plus randomized traffic against
// a behavioural model. Define LFSR_SEQ_SEED_EN to also exercise seeding.
module tb_lfsr_seq_gen;
  localparam int unsigned WIDTH    = 16;
  localparam int unsigned OUT_BITS = 4;
  localparam int unsigned MAX_LEN  = 32;
  localparam int unsigned IDXW     = 5;
  localparam logic [15:0] TAPS     = 16'h002D;
  localparam logic [15:0] FILL     = 16'hACE1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lfsr_seq_gen_if #(.WIDTH(WIDTH), .OUT_BITS(OUT_BITS), .MAX_LEN(MAX_LEN)) bus ();

  lfsr_seq_gen #(
    .WIDTH(WIDTH), .TAPS(TAPS), .FILL(FILL), .OUT_BITS(OUT_BITS), .MAX_LEN(MAX_LEN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Reference state: sequence register, saved replay point, position, previous randomize level
  logic [15:0] m_lfsr;
  logic [15:0] m_chk;
  int          m_idx;
  bit          m_rprev;

  function automatic logic [15:0] advance(input logic [15:0] s);
    int          fb;
    logic [15:0] n;
    fb = $countones(s & TAPS) % 2;
    n  = (s >> 1) + (fb != 0 ? 16'h8000 : 16'h0000);
    return (n == 16'h0) ? FILL : n;
  endfunction

  task automatic set_idle();
    bus.step         = 1'b0;
    bus.randomize_en = 1'b0;
    bus.rerun        = 1'b0;
`ifdef LFSR_SEQ_SEED_EN
    bus.seed_load    = 1'b0;
    bus.seed_in      = 16'h0;
`endif
  endtask

  // One clock: predict from the inputs now applied, then sample #1 after the edge.
  task automatic tick();
    logic [15:0] nl;
    logic [15:0] nc;
    int          ni;
    bit          at_end;
    bit          fell;
    nl     = m_lfsr;
    nc     = m_chk;
    ni     = m_idx;
    at_end = (m_idx == int'(bus.round_len));
    fell   = !bus.randomize_en && m_rprev;
    if (reset) begin
      nl = FILL; nc = FILL; ni = 0;
    end else if (bus.rerun) begin
      nl = m_chk; ni = 0;
    end
`ifdef LFSR_SEQ_SEED_EN
    else if (bus.seed_load) begin
      nl = (bus.seed_in == 16'h0) ? FILL : bus.seed_in;
      nc = nl;
      ni = 0;
    end
`endif
    else if (bus.randomize_en) begin
      nl = advance(m_lfsr); ni = 0;
    end else if (fell) begin
      nc = m_lfsr; ni = 0;
    end else if (bus.step && !at_end) begin
      nl = advance(m_lfsr);
      if (m_idx < int'(MAX_LEN) - 1) ni = m_idx + 1;
    end
    @(posedge clk);
    #1;
    m_lfsr  = nl;
    m_chk   = nc;
    m_idx   = ni;
    m_rprev = reset ? 1'b0 : bus.randomize_en;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_idle();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_idle();
    bus.round_len = 5'd0;
    tick();
    tick();
    n_checks++;
    if (bus.random !== 4'h1) begin
      n_fails++; $display("FAIL reset_random: got %h want 1", bus.random);
    end
    n_checks++;
    if (bus.index !== 5'd0) begin
      n_fails++; $display("FAIL reset_index: got %0d want 0", bus.index);
    end
    n_checks++;
    if (bus.last !== 1'b1) begin
      n_fails++; $display("FAIL reset_last_len0: got %b want 1", bus.last);
    end
    bus.round_len = 5'd3;
    #1;
    n_checks++;
    if (bus.last !== 1'b0) begin
      n_fails++; $display("FAIL reset_last_len3: got %b want 0", bus.last);
    end
    reset = 1'b0;
  endtask

  task automatic test_step();
    do_reset();
    bus.round_len = 5'd5;
    bus.step = 1'b1;
    tick();
    n_checks++;
    if (dut.lfsr_q !== 16'h5670 || bus.random !== 4'h0) begin
      n_fails++; $display("FAIL step1: got %h/%h want 5670/0", dut.lfsr_q, bus.random);
    end
    tick();
    bus.step = 1'b0;
    n_checks++;
    if (dut.lfsr_q !== 16'hAB38 || bus.random !== 4'h8) begin
      n_fails++; $display("FAIL step2: got %h/%h want ab38/8", dut.lfsr_q, bus.random);
    end
    n_checks++;
    if (bus.index !== 5'd2) begin
      n_fails++; $display("FAIL step_index: got %0d want 2", bus.index);
    end
  endtask

  task automatic test_randomize_rerun();
    do_reset();
    bus.round_len = 5'd5;
    bus.randomize_en = 1'b1;
    repeat (3) tick();
    bus.randomize_en = 1'b0;
    tick();
    n_checks++;
    if (dut.chk_q !== 16'h559C || bus.index !== 5'd0) begin
      n_fails++; $display("FAIL checkpoint: got %h/%0d want 559c/0", dut.chk_q, bus.index);
    end
    bus.step = 1'b1;
    repeat (3) tick();
    bus.step = 1'b0;
    n_checks++;
    if (bus.index !== 5'd3) begin
      n_fails++; $display("FAIL steps_after_cp: got %0d want 3", bus.index);
    end
    bus.rerun = 1'b1;
    tick();
    bus.rerun = 1'b0;
    n_checks++;
    if (dut.lfsr_q !== 16'h559C || bus.index !== 5'd0 || bus.random !== 4'hC) begin
      n_fails++;
      $display("FAIL rerun: got %h/%0d/%h want 559c/0/c", dut.lfsr_q, bus.index, bus.random);
    end
  endtask

  task automatic test_last_stop();
    do_reset();
    bus.round_len = 5'd2;
    bus.step = 1'b1;
    repeat (4) tick();
    bus.step = 1'b0;
    n_checks++;
    if (bus.index !== 5'd2 || bus.last !== 1'b1) begin
      n_fails++; $display("FAIL last_stop: got %0d/%b want 2/1", bus.index, bus.last);
    end
    n_checks++;
    if (dut.lfsr_q !== 16'hAB38) begin
      n_fails++; $display("FAIL last_lfsr: got %h want ab38", dut.lfsr_q);
    end
  endtask

  task automatic test_rerun_vs_fall();
    do_reset();
    bus.randomize_en = 1'b1;
    repeat (3) tick();
    bus.randomize_en = 1'b0;
    tick();
    bus.randomize_en = 1'b1;
    repeat (2) tick();
    bus.randomize_en = 1'b0;
    bus.rerun = 1'b1;
    tick();
    bus.rerun = 1'b0;
    n_checks++;
    if (dut.lfsr_q !== 16'h559C || dut.chk_q !== 16'h559C) begin
      n_fails++; $display("FAIL rerun_fall: got %h/%h want 559c/559c", dut.lfsr_q, dut.chk_q);
    end
    tick();
    n_checks++;
    if (dut.chk_q !== 16'h559C || dut.lfsr_q !== 16'h559C) begin
      n_fails++; $display("FAIL no_late_edge: got %h/%h want 559c/559c", dut.lfsr_q, dut.chk_q);
    end
  endtask

  task automatic test_reset_mid_randomize();
    do_reset();
    bus.randomize_en = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.randomize_en = 1'b0;
    tick();
    n_checks++;
    if (dut.chk_q !== FILL || dut.lfsr_q !== FILL || bus.index !== 5'd0) begin
      n_fails++;
      $display("FAIL reset_mid_rand: got %h/%h/%0d want ace1/ace1/0",
               dut.lfsr_q, dut.chk_q, bus.index);
    end
  endtask

`ifdef LFSR_SEQ_SEED_EN
  task automatic test_seed();
    do_reset();
    bus.seed_load = 1'b1;
    bus.seed_in   = 16'h0000;
    tick();
    n_checks++;
    if (dut.lfsr_q !== FILL || dut.chk_q !== FILL) begin
      n_fails++; $display("FAIL seed_zero: got %h/%h want ace1", dut.lfsr_q, dut.chk_q);
    end
    bus.seed_in = 16'h1234;
    tick();
    bus.seed_load = 1'b0;
    n_checks++;
    if (bus.random !== 4'h4 || dut.lfsr_q !== 16'h1234 || bus.index !== 5'd0) begin
      n_fails++;
      $display("FAIL seed_1234: got %h/%h/%0d want 4/1234/0", bus.random, dut.lfsr_q, bus.index);
    end
  endtask
`endif

  task automatic test_random();
    int run_left;
    logic [IDXW-1:0] exp_idx;
    run_left = 0;
    do_reset();
    bus.round_len = 5'd6;
    for (int i = 0; i < 800; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      bus.rerun = ($urandom_range(0, 24) == 0);
      bus.step  = $urandom_range(0, 1) != 0;
      if (run_left > 0) begin
        run_left--;
        bus.randomize_en = 1'b1;
      end else begin
        bus.randomize_en = 1'b0;
        if ($urandom_range(0, 29) == 0) run_left = $urandom_range(1, 6);
      end
      if ($urandom_range(0, 39) == 0) bus.round_len = IDXW'($urandom_range(0, 31));
`ifdef LFSR_SEQ_SEED_EN
      bus.seed_load = ($urandom_range(0, 39) == 0);
      bus.seed_in   = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
`endif
      tick();
      exp_idx = IDXW'(m_idx);
      n_checks++;
      if (bus.random !== m_lfsr[OUT_BITS-1:0] || dut.lfsr_q !== m_lfsr) begin
        n_fails++;
        $display("FAIL rand_lfsr[%0d]: got %h want %h", i, dut.lfsr_q, m_lfsr);
      end
      n_checks++;
      if (bus.index !== exp_idx) begin
        n_fails++; $display("FAIL rand_index[%0d]: got %0d want %0d", i, bus.index, m_idx);
      end
      n_checks++;
      if (bus.last !== (m_idx == int'(bus.round_len))) begin
        n_fails++; $display("FAIL rand_last[%0d]: got %b want %b", i, bus.last,
                            (m_idx == int'(bus.round_len)));
      end
    end
    reset = 1'b0;
    set_idle();
  endtask

  initial begin
    reset = 1'b1;
    set_idle();
    bus.round_len = '0;
    m_lfsr  = FILL;
    m_chk   = FILL;
    m_idx   = 0;
    m_rprev = 1'b0;
    test_reset();
    test_step();
    test_randomize_rerun();
    test_last_stop();
    test_rerun_vs_fall();
    test_reset_mid_randomize();
`ifdef LFSR_SEQ_SEED_EN
    test_seed();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
